// File: rtl/rr_prio_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_prio_arbiter_if
//  Description : Request/grant bundle between requesters and rr_prio_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rr_prio_arbiter_if #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
);
    logic             en;
    logic             mode;
    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;

    modport master (
        output en, mode, req,
        input  gnt, gnt_valid, gnt_idx
    );

    modport slave (
        input  en, mode, req,
        output gnt, gnt_valid, gnt_idx
    );
endinterface
`default_nettype wire

// File: rtl/rr_prio_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_prio_arbiter
//  Description : N-way fixed-priority / round-robin arbiter with optional
//                grant lock and a registered one-hot grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_prio_arbiter #(
    parameter int N     = 8,
    parameter bit LOCK  = 1'b0,
    parameter int IDX_W = $clog2(N)
) (
    input  wire logic         clock,
    input  wire logic         reset,
    rr_prio_arbiter_if.slave  bus
);

    localparam logic [IDX_W-1:0] c_last = IDX_W'(N - 1);
    localparam logic [IDX_W:0]   c_n    = (IDX_W + 1)'(N);

    logic [N-1:0]     r_gnt;
    logic             r_valid;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_ptr;

    logic [IDX_W-1:0] w_fix_idx;
    logic [IDX_W-1:0] w_rr_idx;
    logic [IDX_W-1:0] w_rr_ptr;
    logic             w_any_req;
    logic             w_lock_hit;

    logic [N-1:0]     w_gnt_nxt;
    logic             w_valid_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [IDX_W-1:0] w_ptr_nxt;

    assign w_any_req  = |bus.req;
    assign w_lock_hit = LOCK && (|(r_gnt & bus.req));

    // Ascending scan so the highest set index is the last one written.
    always_comb begin
        w_fix_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.req[i]) w_fix_idx = i[IDX_W-1:0];
        end
    end

    // Descending distance scan from ptr so the nearest requester wins.
    always_comb begin
        logic [IDX_W:0] w_pos;
        w_rr_idx = '0;
        w_pos    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = {1'b0, r_ptr} + (IDX_W + 1)'(k);
            if (w_pos >= c_n) w_pos = w_pos - c_n;
            if (bus.req[w_pos[IDX_W-1:0]]) w_rr_idx = w_pos[IDX_W-1:0];
        end
    end

    assign w_rr_ptr = (w_rr_idx == c_last) ? '0 : w_rr_idx + 1'b1;

    always_comb begin
        w_gnt_nxt   = r_gnt;
        w_valid_nxt = r_valid;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
        if (!bus.en || (!w_lock_hit && !w_any_req)) begin
            w_gnt_nxt   = '0;
            w_valid_nxt = 1'b0;
            w_idx_nxt   = '0;
        end else if (!w_lock_hit) begin
            w_valid_nxt = 1'b1;
            if (!bus.mode) begin
                w_idx_nxt = w_fix_idx;
            end else begin
                w_idx_nxt = w_rr_idx;
                w_ptr_nxt = w_rr_ptr;
            end
            w_gnt_nxt            = '0;
            w_gnt_nxt[w_idx_nxt] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_ptr   <= '0;
        end else begin
            r_gnt   <= w_gnt_nxt;
            r_valid <= w_valid_nxt;
            r_idx   <= w_idx_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_valid = r_valid;
    assign bus.gnt_idx   = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_rr_prio_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_prio_arbiter
//  Description : Directed bench for rr_prio_arbiter, N=4, LOCK=0 and LOCK=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_prio_arbiter;

    localparam int N = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         en;
    logic         mode;
    logic [N-1:0] req;

    int vectors    = 0;
    int miscompares = 0;

    rr_prio_arbiter_if #(.N(N)) ifa ();
    rr_prio_arbiter_if #(.N(N)) ifb ();

    assign ifa.en = en;  assign ifa.mode = mode;  assign ifa.req = req;
    assign ifb.en = en;  assign ifb.mode = mode;  assign ifb.req = req;

    rr_prio_arbiter #(.N(N), .LOCK(1'b0)) u_a (.clock(clock), .reset(reset), .bus(ifa));
    rr_prio_arbiter #(.N(N), .LOCK(1'b1)) u_b (.clock(clock), .reset(reset), .bus(ifb));

    always #5 clock = ~clock;

    task automatic step(input logic r, input logic e, input logic m, input logic [N-1:0] q);
        reset = r; en = e; mode = m; req = q;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks gnt/gnt_idx/gnt_valid of instance A (LOCK=0) and its ptr.
    task automatic chk_a(input string tag, input logic [3:0] g, input logic [1:0] i,
                         input logic v, input logic [1:0] p);
        chk({tag, ".a.gnt"},   {4'h0, ifa.gnt},      {4'h0, g});
        chk({tag, ".a.idx"},   {6'h0, ifa.gnt_idx},  {6'h0, i});
        chk({tag, ".a.valid"}, {7'h0, ifa.gnt_valid}, {7'h0, v});
        chk({tag, ".a.ptr"},   {6'h0, u_a.r_ptr},    {6'h0, p});
    endtask

    task automatic chk_b(input string tag, input logic [3:0] g, input logic [1:0] i,
                         input logic v, input logic [1:0] p);
        chk({tag, ".b.gnt"},   {4'h0, ifb.gnt},      {4'h0, g});
        chk({tag, ".b.idx"},   {6'h0, ifb.gnt_idx},  {6'h0, i});
        chk({tag, ".b.valid"}, {7'h0, ifb.gnt_valid}, {7'h0, v});
        chk({tag, ".b.ptr"},   {6'h0, u_b.r_ptr},    {6'h0, p});
    endtask

    initial begin
        // Reset held two cycles with all requesting
        step(1, 1, 0, 4'b1111); chk_a("rst1", 4'b0000, 0, 0, 0); chk_b("rst1", 4'b0000, 0, 0, 0);
        step(1, 1, 0, 4'b1111); chk_a("rst2", 4'b0000, 0, 0, 0); chk_b("rst2", 4'b0000, 0, 0, 0);
        step(0, 1, 0, 4'b1111); chk_a("post_rst", 4'b1000, 3, 1, 0); chk_b("post_rst", 4'b1000, 3, 1, 0);

        // Fixed priority
        step(0, 1, 0, 4'b0110); chk_a("fix_0110", 4'b0100, 2, 1, 0); chk_b("fix_0110", 4'b0100, 2, 1, 0);
        step(0, 1, 0, 4'b0011); chk_a("fix_0011", 4'b0010, 1, 1, 0);
        step(0, 1, 0, 4'b0000); chk_a("fix_none", 4'b0000, 0, 0, 0); chk_b("fix_none", 4'b0000, 0, 0, 0);

        // Round-robin fairness from a fresh ptr
        step(1, 1, 1, 4'b1111); chk_a("rr_rst", 4'b0000, 0, 0, 0);
        step(0, 1, 1, 4'b1111); chk_a("rr_1", 4'b0001, 0, 1, 1); chk_b("rr_1", 4'b0001, 0, 1, 1);
        step(0, 1, 1, 4'b1111); chk_a("rr_2", 4'b0010, 1, 1, 2); chk_b("rr_lock", 4'b0001, 0, 1, 1);
        step(0, 1, 1, 4'b1111); chk_a("rr_3", 4'b0100, 2, 1, 3);
        step(0, 1, 1, 4'b1111); chk_a("rr_4", 4'b1000, 3, 1, 0);
        step(0, 1, 1, 4'b1111); chk_a("rr_5", 4'b0001, 0, 1, 1);

        // Skip and wrap
        step(0, 1, 1, 4'b0010); chk_a("rr_set2", 4'b0010, 1, 1, 2); chk_b("rr_rel", 4'b0010, 1, 1, 2);
        step(0, 1, 1, 4'b0011); chk_a("rr_wrap", 4'b0001, 0, 1, 1); chk_b("rr_hold", 4'b0010, 1, 1, 2);

        // Lock (instance B) contrasted with no lock (instance A)
        step(1, 1, 0, 4'b0000); chk_b("lk_rst", 4'b0000, 0, 0, 0);
        step(0, 1, 0, 4'b0001); chk_b("lk_g0", 4'b0001, 0, 1, 0);
        for (int c = 0; c < 3; c++) begin
            step(0, 1, 0, 4'b1001);
            chk_b($sformatf("lk_hold%0d", c), 4'b0001, 0, 1, 0);
            chk_a($sformatf("nolk%0d", c), 4'b1000, 3, 1, 0);
        end
        step(0, 1, 0, 4'b1000); chk_b("lk_rel", 4'b1000, 3, 1, 0);

        // Disable and reset mid-grant
        step(0, 1, 1, 4'b0100); chk_a("dis_pre", 4'b0100, 2, 1, 3); chk_b("dis_pre", 4'b0100, 2, 1, 3);
        step(0, 0, 1, 4'b0100); chk_a("dis", 4'b0000, 0, 0, 3); chk_b("dis_lock", 4'b0000, 0, 0, 3);
        step(0, 1, 1, 4'b1111); chk_a("reen", 4'b1000, 3, 1, 0); chk_b("reen", 4'b1000, 3, 1, 0);
        step(0, 1, 1, 4'b1111); chk_a("reen2", 4'b0001, 0, 1, 1); chk_b("reen_lock", 4'b1000, 3, 1, 0);
        step(1, 1, 1, 4'b1111); chk_a("mid_rst", 4'b0000, 0, 0, 0); chk_b("mid_rst", 4'b0000, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_prio_arbiter.md
# rr_prio_arbiter

Parametrised N-way request arbiter with a registered one-hot grant. It generalises the 4-bit enable-gated priority selector in two ways: it adds a run-time choice between fixed-priority and round-robin arbitration, and an optional grant lock that holds a granted requester until it releases. It sits in front of shared resources such as a CDB port, a memory port or functional-unit issue, and produces one grant per cycle.

## Interface
- `N`, default 8: number of requesters; legal range is N ≥ 2.
- `LOCK`, default 0: when 1, a granted requester keeps the grant while its request stays asserted.
- `IDX_W`, default $clog2(N): width of the grant index; derived, not overridden.

Ports:
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `en` input 1: arbitration enable; when low, no grant is issued.
- `mode` input 1: 0 = fixed priority (highest index wins), 1 = round-robin.
- `req` input N: request vector, one bit per requester.
- `gnt` output N: registered grant, one-hot or all-zero.
- `gnt_valid` output 1: registered; equals |gnt.
- `gnt_idx` output IDX_W: registered index of the set `gnt` bit; 0 when `gnt_valid`=0.

## Operation
- State held: `gnt`, `gnt_valid`, `gnt_idx`, and the round-robin pointer `ptr` (IDX_W bits, values 0..N-1).
- Reset: `gnt`=0, `gnt_valid`=0, `gnt_idx`=0, `ptr`=0.
- Each cycle the next grant is computed combinationally from `req`, `en`, `mode`, the current grant and `ptr`, then registered. The rules below apply in priority order.
  1. `en`=0: next `gnt`=0. `ptr` holds.
  2. Lock: applies when `LOCK`=1, `gnt[i]`=1 and `req[i]`=1. Next `gnt`=`gnt`, regardless of `mode` or other requests; higher-priority requesters cannot preempt. `ptr` holds.
  3. `req`=0: next `gnt`=0. `ptr` holds.
  4. `mode`=0: grant the highest set index of `req`. `ptr` is not updated.
  5. `mode`=1: search `req` starting at index `ptr` upward, wrapping N-1→0. Grant the first set bit i, and set `ptr` to (i+1) mod N.
- `ptr` wrap: when i=N-1, `ptr` becomes 0.
- Changing `mode` takes effect on the next evaluation. `ptr` keeps its value across fixed-mode periods.
- If a locked requester drops its request, the grant is re-arbitrated in that same evaluation by rules 3–5. There is no idle bubble.
- Invariant: `gnt` is never multi-hot. A set `gnt` bit always corresponds to a `req` bit that was high in the preceding cycle.

## Timing
- Latency is 1 cycle: `req`, `en` or `mode` sampled at edge t is reflected in `gnt`, `gnt_idx` and `gnt_valid` after edge t.
- Release: `req[i]` falling before edge t clears or moves the grant after edge t.
- Reset asserted mid-operation clears all state at that edge. `reset` overrides `en` and the lock.
- All outputs are glitch-free register outputs; there are no combinational input-to-output paths.

## Test plan
The bench uses N=4.
- Reset: hold `reset` high for 2 cycles with `req`=1111, `en`=1, `mode`=0. Outputs are 0 during reset. In the first cycle after reset, `gnt`=1000, `gnt_idx`=3, `gnt_valid`=1.
- Fixed priority, `LOCK`=0, `mode`=0: `req`=0110 gives `gnt`=0100. The next `req`=0011 gives `gnt`=0010. `req`=0000 gives `gnt`=0000 and `gnt_valid`=0.
- Round-robin fairness, `mode`=1, `LOCK`=0, `req`=1111 held after reset: `gnt` sequence is 0001, 0010, 0100, 1000, 0001, with `ptr` wrapping 3→0.
- Round-robin skip and wrap: grant 0010 so that `ptr`=2, then apply `req`=0011. Result is `gnt`=0001, `gnt_idx`=0, `ptr`=1.
- Lock, `LOCK`=1, `mode`=0: `req`=0001 gives `gnt`=0001. Then `req`=1001 keeps `gnt` at 0001 for 3 cycles. Dropping `req[0]` (`req`=1000) gives `gnt`=1000 on the next cycle.
- Disable and reset mid-grant: with `gnt`=0100 in `mode`=1, `en`=0 for one cycle gives `gnt`=0 with `ptr` unchanged. Re-enabling with `req`=1111 grants from `ptr`. Asserting `reset` while `gnt`≠0 gives all outputs 0 and `ptr`=0 at the next edge.
